mem_port_arbiter: RTL

//   Shares the single data-memory port between speculative load reads and committed store writes.
//   - Stores arrive from the store-buffer commit path and are held in a small internal queue.
//   - Load requests come from the load/store issue stage.
//   - Load responses are returned to the ROB after a fixed read latency.
//   - Flush kills in-flight loads only; committed stores always reach memory.

---
 rtl/mem_port_if.sv | 40 ++++
 rtl/mem_port_arbiter.sv | 150 +++++++++++++++
 2 files changed

// File: rtl/mem_port_if.sv
// Bundles the load, store, memory and response signals of the data-memory
// port arbiter. The arbiter connects to the slave modport and the
// requesters/memory to the master modport.
interface mem_port_if #(
   parameter int ADDR_W = 16,
   parameter int DATA_W = 16,
   parameter int ROB_W  = 6
);
   logic              ld_valid;
   logic [ADDR_W-1:0] ld_addr;
   logic [ROB_W-1:0]  ld_rob;
   logic              ld_ready;

   logic              st_valid;
   logic [ADDR_W-1:0] st_addr;
   logic [DATA_W-1:0] st_data;
   logic              st_ready;

   logic              mem_ren;
   logic              mem_wen;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;

   logic              resp_valid;
   logic [DATA_W-1:0] resp_data;
   logic [ROB_W-1:0]  resp_rob;

   modport slave (
      input  ld_valid, ld_addr, ld_rob, st_valid, st_addr, st_data, mem_rdata,
      output ld_ready, st_ready, mem_ren, mem_wen, mem_addr, mem_wdata,
             resp_valid, resp_data, resp_rob
   );

   modport master (
      output ld_valid, ld_addr, ld_rob, st_valid, st_addr, st_data, mem_rdata,
      input  ld_ready, st_ready, mem_ren, mem_wen, mem_addr, mem_wdata,
             resp_valid, resp_data, resp_rob
   );
endinterface

// File: rtl/mem_port_arbiter.sv
// Shares one data-memory port between speculative loads and committed
// stores. Stores are queued; a load that matches a queued or arriving store
// address waits until those stores drain. Load responses come back through a
// fixed-latency tag pipeline that a flush empties. Committed stores are never
// dropped by a flush.
module mem_port_arbiter #(
   parameter int ADDR_W       = 16,
   parameter int DATA_W       = 16,
   parameter int ROB_W        = 6,
   parameter int READ_LATENCY = 3,
   parameter int STQ_DEPTH    = 4,
   parameter int STARVE_LIMIT = 4
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       flush,
   mem_port_if.slave                  bus,
   output logic [$clog2(STQ_DEPTH):0] stq_count,
   output logic                       busy
);
   localparam int PTR_W = $clog2(STQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int SV_W  = $clog2(STARVE_LIMIT + 1);
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(STQ_DEPTH);
   localparam logic [SV_W-1:0]  LIMIT_C = SV_W'(STARVE_LIMIT);

   typedef enum logic [1:0] {GNT_IDLE, GNT_LOAD, GNT_STORE} grant_t;

   logic [ADDR_W-1:0]       addr_q [STQ_DEPTH];
   logic [ADDR_W-1:0]       addr_d [STQ_DEPTH];
   logic [DATA_W-1:0]       data_q [STQ_DEPTH];
   logic [DATA_W-1:0]       data_d [STQ_DEPTH];
   logic [PTR_W-1:0]        head_q, head_d, tail_q, tail_d;
   logic [CNT_W-1:0]        count_q, count_d;
   logic [SV_W-1:0]         starve_q, starve_d;
   logic [READ_LATENCY-1:0] pipe_vld_q, pipe_vld_d;
   logic [ROB_W-1:0]        pipe_rob_q [READ_LATENCY];
   logic [ROB_W-1:0]        pipe_rob_d [READ_LATENCY];

   grant_t           grant;
   logic             hazard, nonempty, full, enq, deq, st_rdy, resp_vld;
   logic [PTR_W-1:0] off;

   // Store-queue status, address hazard detection and the grant decision.
   always_comb begin
      nonempty = (count_q != '0);
      full     = (count_q == DEPTH_C);
      st_rdy   = rst_n & (count_q < DEPTH_C);
      hazard   = 1'b0;
      off      = '0;
      for (int i = 0; i < STQ_DEPTH; i++) begin
         // Slot i holds a live entry when its distance from head is below count.
         off = PTR_W'(i) - head_q;
         if (({1'b0, off} < count_q) && (addr_q[i] == bus.ld_addr)) hazard = 1'b1;
      end
      if (bus.st_valid && st_rdy && (bus.st_addr == bus.ld_addr)) hazard = 1'b1;
      hazard = hazard & bus.ld_valid;

      grant = GNT_IDLE;
      if (!rst_n)                                                    grant = GNT_IDLE;
      else if (nonempty && (full || (starve_q >= LIMIT_C) || hazard)) grant = GNT_STORE;
      else if (bus.ld_valid && !flush && !hazard)                    grant = GNT_LOAD;
      else if (nonempty)                                             grant = GNT_STORE;
   end

   // Memory strobes, address/data mux and handshake outputs follow the grant.
   always_comb begin
      bus.ld_ready  = (grant == GNT_LOAD);
      bus.st_ready  = st_rdy;
      bus.mem_ren   = (grant == GNT_LOAD);
      bus.mem_wen   = (grant == GNT_STORE);
      bus.mem_addr  = '0;
      bus.mem_wdata = '0;
      if (grant == GNT_STORE) begin
         bus.mem_addr  = addr_q[head_q];
         bus.mem_wdata = data_q[head_q];
      end else if (grant == GNT_LOAD) begin
         bus.mem_addr  = bus.ld_addr;
      end
      resp_vld       = pipe_vld_q[READ_LATENCY-1];
      bus.resp_valid = resp_vld;
      bus.resp_rob   = pipe_rob_q[READ_LATENCY-1];
      bus.resp_data  = resp_vld ? bus.mem_rdata : '0;
      stq_count      = count_q;
      busy           = nonempty | (|pipe_vld_q);
   end

   // Next-state for queue pointers, starve counter and the load tag pipeline.
   always_comb begin
      enq      = bus.st_valid & st_rdy;
      deq      = (grant == GNT_STORE);
      addr_d   = addr_q;
      data_d   = data_q;
      head_d   = head_q;
      tail_d   = tail_q;
      count_d  = count_q;
      starve_d = starve_q;
      if (enq) begin
         addr_d[tail_q] = bus.st_addr;
         data_d[tail_q] = bus.st_data;
         tail_d         = tail_q + PTR_W'(1);
      end
      if (deq) head_d = head_q + PTR_W'(1);
      case ({enq, deq})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      if (deq)                              starve_d = '0;
      else if (!nonempty)                   starve_d = '0;
      else if (starve_q < LIMIT_C)          starve_d = starve_q + SV_W'(1);

      pipe_vld_d    = '0;
      pipe_rob_d[0] = bus.ld_rob;
      pipe_vld_d[0] = (grant == GNT_LOAD);
      for (int i = 1; i < READ_LATENCY; i++) begin
         pipe_vld_d[i] = pipe_vld_q[i-1];
         pipe_rob_d[i] = pipe_rob_q[i-1];
      end
      // Flush kills every in-flight load; stage 0 is already empty because
      // no load is granted during a flush.
      if (flush) pipe_vld_d = '0;
   end

   // State registers with asynchronous active-low reset.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         starve_q   <= '0;
         pipe_vld_q <= '0;
         for (int i = 0; i < STQ_DEPTH; i++) begin
            addr_q[i] <= '0;
            data_q[i] <= '0;
         end
         for (int i = 0; i < READ_LATENCY; i++) pipe_rob_q[i] <= '0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         starve_q   <= starve_d;
         pipe_vld_q <= pipe_vld_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         pipe_rob_q <= pipe_rob_d;
      end
   end
endmodule
